spiral_multi_gen: RTL and testbench

//   Parametrised rotating-spiral pattern source for the VGA pattern mux; next generation of the 6-arm spiral.

---
 rtl/spiral_multi_gen_if.sv | 24 ++
 rtl/spiral_multi_gen.sv | 146 ++++++++++++++
 tb/tb_spiral_multi_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/spiral_multi_gen_if.sv
// Pixel-stream bundle between the VGA timing/mux side and the spiral source.
//   master : drives pattern_enable, x, y, active, next_frame, step_size, mode;
//            receives rgb
//   slave  : the pattern source; consumes the timing inputs, drives rgb
interface spiral_multi_gen_if;
    logic       pattern_enable;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       next_frame;
    logic [2:0] step_size;
    logic [1:0] mode;
    logic [5:0] rgb;

    modport master (
        output pattern_enable, x, y, active, next_frame, step_size, mode,
        input  rgb
    );

    modport slave (
        input  pattern_enable, x, y, active, next_frame, step_size, mode,
        output rgb
    );
endinterface

// File: rtl/spiral_multi_gen.sv
// Rotating multi-arm spiral pattern source.
//   clk            : pixel clock
//   rst            : asynchronous, active-high reset
//   bus (slave)    : pattern_enable, x, y, active, next_frame, step_size (quarter
//                    steps per frame), mode (00 CW, 01 CCW, 10 ping-pong,
//                    11 freeze) in; rgb (6-bit, 2-cycle latency) out
module spiral_multi_gen #(
    parameter int unsigned H_CENTER       = 320,
    parameter int unsigned V_CENTER       = 240,
    parameter int unsigned NUM_ARMS       = 6,
    parameter int unsigned RADIUS_SHIFT   = 4,
    parameter int unsigned MIN_RADIUS     = 20,
    parameter int unsigned REVERSE_FRAMES = 64
) (
    input logic                clk,
    input logic                rst,
    spiral_multi_gen_if.slave  bus
);

    localparam logic [9:0]  HC       = 10'(H_CENTER);
    localparam logic [9:0]  VC       = 10'(V_CENTER);
    localparam logic [3:0]  ARMS     = 4'(NUM_ARMS);
    localparam logic [10:0] MIN_R    = 11'(MIN_RADIUS);
    localparam logic [7:0]  LAST_CNT = 8'(REVERSE_FRAMES - 1);

    typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_t;

    dir_t       dir, dir_next;
    logic [7:0] rot_acc, rot_acc_next;
    logic [7:0] frame_cnt, frame_cnt_next;
    logic [5:0] rotation_offset;

    // ---------------- rotation / direction state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir       <= FWD;
            rot_acc   <= '0;
            frame_cnt <= '0;
        end else begin
            dir       <= dir_next;
            rot_acc   <= rot_acc_next;
            frame_cnt <= frame_cnt_next;
        end
    end

    // Step direction comes from the dir held before this pulse; the mode
    // decides the dir for the following pulse.
    always_comb begin
        dir_next       = dir;
        rot_acc_next   = rot_acc;
        frame_cnt_next = frame_cnt;
        if (bus.pattern_enable && bus.next_frame && (bus.mode != 2'b11)) begin
            if (dir == FWD)
                rot_acc_next = rot_acc + {5'b0, bus.step_size};
            else
                rot_acc_next = rot_acc - {5'b0, bus.step_size};
            case (bus.mode)
                2'b00: begin
                    dir_next       = FWD;
                    frame_cnt_next = '0;
                end
                2'b01: begin
                    dir_next       = REV;
                    frame_cnt_next = '0;
                end
                default: begin
                    if (frame_cnt == LAST_CNT) begin
                        dir_next       = (dir == FWD) ? REV : FWD;
                        frame_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rotation_offset = rot_acc[7:2];
    end

    // ---------------- stage 1: geometry ----------------
    logic [9:0]  dx, dy;
    logic [10:0] s1_radius;
    logic [2:0]  s1_sector;
    logic        s1_active;

    always_comb begin
        dx = (bus.x >= HC) ? (bus.x - HC) : (HC - bus.x);
        dy = (bus.y >= VC) ? (bus.y - VC) : (VC - bus.y);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_radius <= '0;
            s1_sector <= '0;
            s1_active <= 1'b0;
        end else begin
            s1_radius <= {1'b0, dx} + {1'b0, dy};
            s1_sector <= {bus.x >= HC, bus.y >= VC, dx > dy};
            s1_active <= bus.active;
        end
    end

    // ---------------- stage 2: arm selection and colour ----------------
    logic [5:0] angle;
    logic [6:0] twist;
    logic [6:0] phase;
    logic [2:0] arm_index;
    logic       in_arm;
    logic [5:0] palette_colour;
    logic [5:0] rgb_q;

    always_comb begin
        angle     = {s1_sector, 3'b000} + rotation_offset;
        twist     = 7'(s1_radius >> RADIUS_SHIFT);
        phase     = {1'b0, angle} - twist;
        arm_index = phase[6:4];
        in_arm    = !phase[3] && ({1'b0, arm_index} < ARMS) && (s1_radius > MIN_R);
    end

    always_comb begin
        palette_colour = '0;
        case (arm_index)
            3'd0: palette_colour = 6'b010001;
            3'd1: palette_colour = 6'b100011;
            3'd2: palette_colour = 6'b111010;
            3'd3: palette_colour = 6'b001110;
            3'd4: palette_colour = 6'b011101;
            3'd5: palette_colour = 6'b101111;
            3'd6: palette_colour = 6'b110100;
            3'd7: palette_colour = 6'b001011;
            default: palette_colour = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rgb_q <= '0;
        else
            rgb_q <= (s1_active && in_arm) ? palette_colour : '0;
    end

    assign bus.rgb = rgb_q;

endmodule

// File: tb/tb_spiral_multi_gen.sv
// Directed bench for spiral_multi_gen: a default build (6 arms, 64-frame
// dwell) and a 3-arm / 4-frame-dwell build driven with identical inputs.
module tb_spiral_multi_gen;

    logic clk;
    logic rst;

    spiral_multi_gen_if bus ();
    spiral_multi_gen_if bus2 ();

    assign bus2.pattern_enable = bus.pattern_enable;
    assign bus2.x              = bus.x;
    assign bus2.y              = bus.y;
    assign bus2.active         = bus.active;
    assign bus2.next_frame     = bus.next_frame;
    assign bus2.step_size      = bus.step_size;
    assign bus2.mode           = bus.mode;

    spiral_multi_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    spiral_multi_gen #(
        .NUM_ARMS       (3),
        .REVERSE_FRAMES (4)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic [5:0] exp6;
        logic [5:0] exp3;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the second following edge.
    task automatic apply(input logic [9:0] px, input logic [9:0] py, input logic act);
        bus.x      = px;
        bus.y      = py;
        bus.active = act;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            bus.pattern_enable = en;
            bus.next_frame     = 1'b1;
            @(posedge clk);
            #1;
            bus.next_frame     = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = '{x: 10'd290, y: 10'd230, act: 1'b1, exp6: 6'b010001, exp3: 6'b010001};
        vecs[1]  = '{x: 10'd290, y: 10'd230, act: 1'b0, exp6: 6'b000000, exp3: 6'b000000};
        vecs[2]  = '{x: 10'd325, y: 10'd240, act: 1'b1, exp6: 6'b000000, exp3: 6'b000000};
        vecs[3]  = '{x: 10'd320, y: 10'd240, act: 1'b1, exp6: 6'b000000, exp3: 6'b000000};
        vecs[4]  = '{x: 10'd280, y: 10'd250, act: 1'b1, exp6: 6'b100011, exp3: 6'b100011};
        vecs[5]  = '{x: 10'd360, y: 10'd230, act: 1'b1, exp6: 6'b111010, exp3: 6'b111010};
        vecs[6]  = '{x: 10'd400, y: 10'd250, act: 1'b1, exp6: 6'b001110, exp3: 6'b000000};
        vecs[7]  = '{x: 10'd200, y: 10'd100, act: 1'b1, exp6: 6'b000000, exp3: 6'b000000};
        vecs[8]  = '{x: 10'd310, y: 10'd260, act: 1'b1, exp6: 6'b000000, exp3: 6'b000000};
        vecs[9]  = '{x: 10'd304, y: 10'd235, act: 1'b1, exp6: 6'b010001, exp3: 6'b010001};
        vecs[10] = '{x: 10'd305, y: 10'd235, act: 1'b1, exp6: 6'b000000, exp3: 6'b000000};

        rst                = 1'b1;
        bus.pattern_enable = 1'b0;
        bus.x              = '0;
        bus.y              = '0;
        bus.active         = 1'b0;
        bus.next_frame     = 1'b0;
        bus.step_size      = '0;
        bus.mode           = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_rgb", {2'b0, bus.rgb}, 8'd0);
        check("reset_rot_acc", dut.rot_acc, 8'd0);
        rst = 1'b0;

        // Pixel table at rotation offset 0
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i].x, vecs[i].y, vecs[i].act);
            check($sformatf("pix%0d_6arm", i), {2'b0, bus.rgb}, {2'b0, vecs[i].exp6});
            check($sformatf("pix%0d_3arm", i), {2'b0, bus2.rgb}, {2'b0, vecs[i].exp3});
        end

        // Exact two-cycle latency: dark pixel, then a lit one
        apply(10'd320, 10'd240, 1'b1);
        bus.x = 10'd290;
        bus.y = 10'd230;
        @(posedge clk);
        #1;
        check("latency_1clk", {2'b0, bus.rgb}, 8'd0);
        @(posedge clk);
        #1;
        check("latency_2clk", {2'b0, bus.rgb}, {2'b0, 6'b010001});

        // Forward stepping and enable gating
        bus.mode      = 2'b00;
        bus.step_size = 3'd4;
        pulses(3, 1'b1);
        check("cw_3_pulses", dut.rot_acc, 8'd12);
        pulses(2, 1'b0);
        check("disabled_hold", dut.rot_acc, 8'd12);
        apply(10'd310, 10'd260, 1'b1);
        check("offset3_arm1", {2'b0, bus.rgb}, {2'b0, 6'b100011});
        apply(10'd290, 10'd230, 1'b1);
        check("offset3_gap", {2'b0, bus.rgb}, 8'd0);

        // Upward wrap
        do_reset();
        bus.step_size = 3'd7;
        pulses(37, 1'b1);
        check("cw_wrap", dut.rot_acc, 8'd3);

        // Reverse wrap below zero; step 0 pulse only sets direction
        do_reset();
        bus.mode      = 2'b01;
        bus.step_size = 3'd0;
        pulses(1, 1'b1);
        check("ccw_step0_hold", dut.rot_acc, 8'd0);
        bus.step_size = 3'd1;
        pulses(1, 1'b1);
        check("ccw_wrap", dut.rot_acc, 8'd255);

        // Ping-pong on the 4-frame build
        do_reset();
        bus.mode      = 2'b10;
        bus.step_size = 3'd4;
        begin
            logic [7:0] pp_exp[8];
            pp_exp = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd12, 8'd8, 8'd4, 8'd0};
            for (int i = 0; i < 8; i++) begin
                pulses(1, 1'b1);
                check($sformatf("pingpong_%0d", i), dut2.rot_acc, pp_exp[i]);
            end
        end
        pulses(1, 1'b1);
        check("pingpong_back_fwd", dut2.rot_acc, 8'd4);
        check("pingpong_long_dwell", dut.rot_acc, 8'd36);

        // Freeze
        bus.mode = 2'b11;
        pulses(3, 1'b1);
        check("freeze_4frame", dut2.rot_acc, 8'd4);
        check("freeze_default", dut.rot_acc, 8'd36);

        // Asynchronous reset mid-line
        apply(10'd304, 10'd235, 1'b1);
        check("pre_reset_lit", {2'b0, bus.rgb}, {2'b0, 6'b100011});
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_rgb", {2'b0, bus.rgb}, 8'd0);
        check("async_reset_acc", dut.rot_acc, 8'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_1clk", {2'b0, bus.rgb}, 8'd0);
        @(posedge clk);
        #1;
        check("post_reset_2clk", {2'b0, bus.rgb}, {2'b0, 6'b010001});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
